// File: rtl/capture_scheduler_pkg.sv
// Shared types and helpers for the waveform capture scheduler.
package capture_scheduler_pkg;

    localparam int SAMPLE_W = 18;
    localparam int SRC_W    = 3;

    typedef enum logic [1:0] {
        ST_HOLDOFF   = 2'd0,
        ST_ARMED     = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_WAIT_DISP = 2'd3
    } sched_state_e;

    typedef enum logic [1:0] {
        TRIG_RISE     = 2'd0,
        TRIG_FALL     = 2'd1,
        TRIG_FREE     = 2'd2,
        TRIG_RISE_ALT = 2'd3
    } trig_mode_e;

    // Terminal count of the decimation counter: factor 2**sel, so last value is 2**sel - 1.
    function automatic logic [2:0] decim_last(input logic [1:0] sel);
        return 3'((4'd1 << sel) - 4'd1);
    endfunction

endpackage

// File: rtl/capture_scheduler_decimator.sv
// Counts input sample strobes and emits one decimated strobe per 2**decim_sel inputs.
module capture_scheduler_decimator
    import capture_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       strobe,
    input  logic [1:0] decim_sel,
    output logic       dstb
);

    logic [2:0] count_q;

    // A strobe coincident with clear is discarded so the new factor starts from a clean phase.
    assign dstb = strobe & ~clear & (count_q == decim_last(decim_sel));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (strobe) begin
            count_q <= dstb ? '0 : count_q + 3'd1;
        end
    end

endmodule

// File: rtl/capture_scheduler.sv
// Selects and decimates one audio stream, finds the trigger and paces captures
// against the wave display, feeding a gated sample stream to the capture engine.
module capture_scheduler
    import capture_scheduler_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int HOLDOFF      = 16,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         new_sample_ready,
    input  logic [SAMPLE_W*NUM_SRC-1:0]  src_samples,
    input  logic                         src_next,
    input  logic [1:0]                   trig_mode,
    input  logic [1:0]                   decim_sel,
    input  logic                         cap_done,
    input  logic                         wave_display_idle,
    output logic                         cap_sample_ready,
    output logic [SAMPLE_W-1:0]          cap_sample,
    output logic                         cap_trigger,
    output logic                         cap_run,
    output logic [SRC_W-1:0]             active_src,
    output logic                         timeout_flag,
    output sched_state_e                 state_dbg
);

    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int TMO_W  = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(AUTO_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(AUTO_TIMEOUT);

    sched_state_e        state_q, state_d;
    trig_mode_e          mode_q;
    logic [1:0]          decim_q;
    logic                apply_q, apply_d;
    logic [SRC_W-1:0]    pending_q, pending_next;
    logic                prev_valid_q, prev_neg_q;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_d;
    logic                fwd, trig_d, tflag_d;
    logic                dstb, rise, fall, natural_trig;
    logic [SAMPLE_W-1:0] cur_sample;

    capture_scheduler_decimator u_decim (
        .clk       (clk),
        .reset     (reset),
        .clear     (apply_q),
        .strobe    (new_sample_ready),
        .decim_sel (decim_q),
        .dstb      (dstb)
    );

    always_comb begin
        cur_sample = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (active_src == SRC_W'(i)) cur_sample = src_samples[SAMPLE_W*i +: SAMPLE_W];
        end
    end

    assign pending_next = (pending_q == SRC_W'(NUM_SRC - 1)) ? '0 : pending_q + SRC_W'(1);
    assign rise = prev_valid_q & prev_neg_q & ~cur_sample[SAMPLE_W-1];
    assign fall = prev_valid_q & ~prev_neg_q & cur_sample[SAMPLE_W-1];
    assign natural_trig = (mode_q == TRIG_FREE)
                        | (((mode_q == TRIG_RISE) | (mode_q == TRIG_RISE_ALT)) & rise)
                        | ((mode_q == TRIG_FALL) & fall);

    // Output contract: cap_sample_ready is a one-cycle strobe, cap_sample is valid with it
    // and holds until the next strobe; cap_trigger only ever rises together with cap_sample_ready.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_cnt_q;
        tmo_d   = tmo_cnt_q;
        fwd     = 1'b0;
        trig_d  = 1'b0;
        tflag_d = timeout_flag;
        apply_d = 1'b0;
        case (state_q)
            ST_HOLDOFF: begin
                if (dstb) begin
                    if (HOLDOFF == 0 || hold_cnt_q >= HOLD_LAST) begin
                        state_d = ST_ARMED;
                        hold_d  = '0;
                        tmo_d   = '0;
                    end else begin
                        hold_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end
            ST_ARMED: begin
                if (dstb) begin
                    if (natural_trig) begin
                        state_d = ST_CAPTURE;
                        fwd     = 1'b1;
                        trig_d  = 1'b1;
                        tflag_d = 1'b0;
                    end else begin
                        if (tmo_cnt_q != TMO_MAX) tmo_d = tmo_cnt_q + TMO_W'(1);
                        if (tmo_cnt_q >= TMO_LAST) begin
                            state_d = ST_CAPTURE;
                            fwd     = 1'b1;
                            trig_d  = 1'b1;
                            tflag_d = 1'b1;
                        end
                    end
                end
            end
            ST_CAPTURE: begin
                if (cap_done) state_d = ST_WAIT_DISP;
                else if (dstb) fwd = 1'b1;
            end
            ST_WAIT_DISP: begin
                if (wave_display_idle) begin
                    state_d = ST_HOLDOFF;
                    apply_d = 1'b1;
                end
            end
            default: state_d = ST_HOLDOFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_HOLDOFF;
            apply_q          <= 1'b1;
            pending_q        <= '0;
            active_src       <= '0;
            mode_q           <= TRIG_RISE;
            decim_q          <= '0;
            prev_valid_q     <= 1'b0;
            prev_neg_q       <= 1'b0;
            hold_cnt_q       <= '0;
            tmo_cnt_q        <= '0;
            cap_sample_ready <= 1'b0;
            cap_sample       <= '0;
            cap_trigger      <= 1'b0;
            timeout_flag     <= 1'b0;
        end else begin
            state_q          <= state_d;
            apply_q          <= apply_d;
            hold_cnt_q       <= hold_d;
            tmo_cnt_q        <= tmo_d;
            timeout_flag     <= tflag_d;
            cap_sample_ready <= fwd;
            cap_trigger      <= trig_d;
            if (fwd) cap_sample <= cur_sample;
            if (src_next) pending_q <= pending_next;
            // The apply cycle takes the pre-increment pending value; a coincident src_next carries over.
            if (apply_q) begin
                active_src   <= pending_q;
                mode_q       <= trig_mode_e'(trig_mode);
                decim_q      <= decim_sel;
                prev_valid_q <= 1'b0;
            end else if (dstb) begin
                prev_valid_q <= 1'b1;
                prev_neg_q   <= cur_sample[SAMPLE_W-1];
            end
        end
    end

    assign cap_run   = (state_q == ST_CAPTURE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_capture_scheduler.sv
// Directed-sequence bench with randomized sample data, checked against a behavioural model.
module tb_capture_scheduler;
    import capture_scheduler_pkg::*;

    localparam int NUM_SRC = 4;
    localparam int HOLDOFF = 16;
    localparam int AUTO_TO = 1024;
    localparam int W       = 18;
    localparam int CAP_LEN = 256;
    localparam int MH = 0, MA = 1, MC = 2, MW = 3;

    // clock / reset / DUT
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic new_sample_ready = 1'b0;
    logic [W*NUM_SRC-1:0] src_samples = '0;
    logic src_next = 1'b0;
    logic [1:0] trig_mode = 2'd0;
    logic [1:0] decim_sel = 2'd0;
    logic cap_done = 1'b0;
    logic wave_display_idle = 1'b0;
    logic cap_sample_ready, cap_trigger, cap_run, timeout_flag;
    logic [W-1:0] cap_sample;
    logic [2:0] active_src;
    sched_state_e state_dbg;

    always #5 clk = ~clk;

    capture_scheduler #(.NUM_SRC(NUM_SRC), .HOLDOFF(HOLDOFF), .AUTO_TIMEOUT(AUTO_TO)) dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .src_samples       (src_samples),
        .src_next          (src_next),
        .trig_mode         (trig_mode),
        .decim_sel         (decim_sel),
        .cap_done          (cap_done),
        .wave_display_idle (wave_display_idle),
        .cap_sample_ready  (cap_sample_ready),
        .cap_sample        (cap_sample),
        .cap_trigger       (cap_trigger),
        .cap_run           (cap_run),
        .active_src        (active_src),
        .timeout_flag      (timeout_flag),
        .state_dbg         (state_dbg)
    );

    // scoreboard and counters
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int dut_ready_cnt = 0;

    // stimulus state
    int period = 4;
    int phase = 0;
    int k = 0;
    bit src0_dc = 1'b0;
    bit done_req = 1'b0;
    int fwd_cnt = 0;

    // reference model state
    int m_state, m_pending, m_active, m_mode, m_decim, m_scnt, m_hold, m_tmo;
    bit m_apply, m_pv, m_pn;
    bit e_ready, e_trig, e_tflag;
    logic [W-1:0] e_sample;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] sine_val(input int idx, input real ph);
        int v;
        v = int'(100000.0 * $sin(real'(idx) * 0.17 + ph)) + int'($urandom_range(0, 7));
        return v[W-1:0];
    endfunction

    task automatic build_samples();
        logic [W-1:0] v;
        for (int i = 0; i < NUM_SRC; i++) begin
            case (i)
                0:       v = src0_dc ? 18'h00100 : sine_val(k, 0.0);
                1:       v = sine_val(k, 1.3);
                default: v = W'($urandom);
            endcase
            src_samples[W*i +: W] = v;
        end
    endtask

    task automatic model_reset();
        m_state = MH; m_apply = 1'b1; m_pending = 0; m_active = 0; m_mode = 0; m_decim = 0;
        m_scnt = 0; m_hold = 0; m_tmo = 0; m_pv = 1'b0; m_pn = 1'b0;
        e_ready = 1'b0; e_trig = 1'b0; e_tflag = 1'b0; e_sample = '0;
        exp_q.delete();
    endtask

    // One clock of the specified behaviour, using the inputs present at the edge.
    task automatic model_step();
        logic [W-1:0] s;
        bit dstb, rise, fall, nat;
        int npend;
        if (reset) begin
            model_reset();
        end else begin
            e_ready = 1'b0;
            e_trig  = 1'b0;
            npend = src_next ? (m_pending + 1) % NUM_SRC : m_pending;
            if (m_apply) begin
                m_active = m_pending; m_mode = trig_mode; m_decim = decim_sel;
                m_scnt = 0; m_pv = 1'b0; m_apply = 1'b0;
            end else begin
                dstb = 1'b0;
                if (new_sample_ready) begin
                    m_scnt++;
                    dstb = (m_scnt % (1 << m_decim)) == 0;
                end
                s = src_samples[W*m_active +: W];
                rise = m_pv && m_pn && !s[W-1];
                fall = m_pv && !m_pn && s[W-1];
                case (m_state)
                    MH: if (dstb) begin
                        m_hold++;
                        if (m_hold >= HOLDOFF) begin m_state = MA; m_hold = 0; m_tmo = 0; end
                    end
                    MA: if (dstb) begin
                        nat = (m_mode == 2) || ((m_mode == 0 || m_mode == 3) && rise) || (m_mode == 1 && fall);
                        if (!nat) m_tmo++;
                        if (nat || m_tmo >= AUTO_TO) begin
                            m_state = MC; e_ready = 1'b1; e_trig = 1'b1; e_tflag = !nat;
                            e_sample = s; exp_q.push_back(s);
                        end
                    end
                    MC: if (cap_done) m_state = MW;
                        else if (dstb) begin e_ready = 1'b1; e_sample = s; exp_q.push_back(s); end
                    default: if (wave_display_idle) begin m_state = MH; m_apply = 1'b1; end
                endcase
                if (dstb) begin m_pv = 1'b1; m_pn = s[W-1]; end
            end
            m_pending = npend;
        end
    endtask

    task automatic check_outputs();
        chk("ready", cap_sample_ready, e_ready);
        chk("trigger", cap_trigger, e_trig);
        chk("run", cap_run, m_state == MC);
        chk("active_src", active_src, m_active);
        chk("timeout_flag", timeout_flag, e_tflag);
        chk("sample_hold", cap_sample, e_sample);
        if (cap_sample_ready === 1'b1) begin
            dut_ready_cnt++;
            if (exp_q.size() > 0) chk("sb_sample", cap_sample, exp_q.pop_front());
            else chk("sb_unexpected", exp_q.size(), 1);
        end else begin
            exp_q.delete();
        end
    endtask

    // driver: one clock with strobe pacing, model update, check and capture-engine response
    task automatic cycle();
        new_sample_ready = (phase == 0);
        phase = (phase + 1) % period;
        if (new_sample_ready) begin
            k++;
            build_samples();
        end
        cap_done = done_req;
        done_req = 1'b0;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        if (e_ready) begin
            fwd_cnt = e_trig ? 1 : fwd_cnt + 1;
            if (fwd_cnt == CAP_LEN) begin done_req = 1'b1; fwd_cnt = 0; end
        end
        src_next = 1'b0;
    endtask

    task automatic wait_state(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && m_state != target; i++) cycle();
        chk(tag, state_dbg, target);
    endtask

    task automatic handoff();
        wave_display_idle = 1'b1;
        cycle();
        wave_display_idle = 1'b0;
    endtask

    initial begin
        int snap;
        model_reset();
        repeat (3) cycle();
        chk("rst_ready", cap_sample_ready, 0);
        chk("rst_run", cap_run, 0);
        chk("rst_trigger", cap_trigger, 0);
        chk("rst_sample", cap_sample, 0);
        chk("rst_active", active_src, 0);
        chk("rst_tflag", timeout_flag, 0);
        chk("rst_state", state_dbg, ST_HOLDOFF);
        reset = 1'b0;

        // sine on src0, rising trigger, no decimation
        wait_state(MC, 3000, "p1_trigger");
        chk("p1_trig_sign", cap_sample[W-1], 0);
        chk("p1_natural", timeout_flag, 0);
        wait_state(MW, 4000, "p1_done");

        // display busy: nothing forwarded, stray cap_done ignored
        snap = dut_ready_cnt;
        repeat (200) cycle();
        done_req = 1'b1;
        repeat (300) cycle();
        chk("p2_no_fwd", dut_ready_cnt - snap, 0);
        chk("p2_still_wait", state_dbg, ST_WAIT_DISP);

        // DC input never crosses: auto trigger after the timeout
        src0_dc = 1'b1;
        period = 2; phase = 0;
        handoff();
        repeat (10) cycle();
        done_req = 1'b1;
        repeat (5) cycle();
        chk("p3_cap_done_ignored", state_dbg, ST_HOLDOFF);
        wait_state(MC, 3000, "p3_forced");
        chk("p3_tflag_set", timeout_flag, 1);
        chk("p3_forced_sample", cap_sample, 18'h00100);
        wait_state(MW, 1000, "p3_done");
        src0_dc = 1'b0;
        handoff();
        wait_state(MC, 2000, "p3_natural");
        chk("p3_tflag_clear", timeout_flag, 0);
        wait_state(MW, 1000, "p3b_done");

        // decimate by 8 on falling edges; mid-capture config change and source steps
        trig_mode = 2'd1;
        decim_sel = 2'd3;
        handoff();
        wait_state(MC, 3000, "p4_trigger");
        decim_sel = 2'd0;
        for (int j = 0; j < 5; j++) begin
            src_next = 1'b1;
            cycle();
            repeat (9) cycle();
        end
        chk("p5_active_hold", active_src, 0);
        wait_state(MW, 6000, "p4_done");
        chk("p5_active_pre", active_src, 0);
        trig_mode = 2'd3;
        handoff();
        cycle();
        chk("p5_active_post", active_src, 1);

        // reset in the middle of a capture
        wait_state(MC, 3000, "p6_trigger");
        repeat (20) cycle();
        reset = 1'b1;
        cycle();
        chk("p6_run", cap_run, 0);
        chk("p6_ready", cap_sample_ready, 0);
        chk("p6_state", state_dbg, ST_HOLDOFF);
        chk("p6_active", active_src, 0);
        chk("p6_sample", cap_sample, 0);
        done_req = 1'b0;
        fwd_cnt = 0;
        reset = 1'b0;
        repeat (40) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
